fft_frame_sched: RTL

//  Frame scheduler and gain controller for the 64-sample, 8-band spectrum engine (fft).

---
 rtl/fft_frame_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - frame scheduler, result latch and AGC for the 8-band spectrum engine
//
// Optional feature macro: FFT_PEAK_HOLD_EN
//   defined     : per-band peak-hold registers drive peak_data (DECAY_SHIFT parameter present)
//   not defined : peak_data is a combinational alias of frame_data
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   enable              1 = schedule frames; 0 = finish the current frame, then idle
//   frame_period[15:0]  cycles between successive triggers; 0 = back-to-back
//   mode_cfg[2:0]       engine mode, sampled on the trigger cycle
//   agc_en              1 = AGC may move fft_gain; 0 = gain frozen
//   fft_trigger         one-cycle trigger pulse to the engine
//   fft_mode[2:0]       mode to the engine, held for the frame
//   fft_gain[7:0]       gain to the engine
//   fft_valid           engine result strobe (only honoured while waiting)
//   fft_data[95:0]      engine result, band k at [12k+11:12k]
//   frame_valid         one-cycle pulse: frame_data updated
//   frame_data[95:0]    last good spectrum, held between frames
//   peak_data[95:0]     per-band peak-hold spectrum
//   frame_cnt[15:0]     completed-frame counter, wraps
//   timeout_err         one-cycle pulse when the engine fails to answer in time
module fft_frame_sched #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned GAIN_INIT = 128,
    parameter int unsigned GAIN_MIN  = 16,
    parameter int unsigned GAIN_MAX  = 255,
    parameter int unsigned GAIN_STEP = 8,
    parameter int unsigned HI_THR    = 3584,
    parameter int unsigned LO_THR    = 1024
`ifdef FFT_PEAK_HOLD_EN
    ,
    parameter int unsigned DECAY_SHIFT = 3
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] frame_period,
    input  logic [2:0]  mode_cfg,
    input  logic        agc_en,
    output logic        fft_trigger,
    output logic [2:0]  fft_mode,
    output logic [7:0]  fft_gain,
    input  logic        fft_valid,
    input  logic [95:0] fft_data,
    output logic        frame_valid,
    output logic [95:0] frame_data,
    output logic [95:0] peak_data,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);
    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_LATCH, S_AGC} state_t;

    localparam logic [15:0] TIMEOUT_C   = 16'(TIMEOUT);
    localparam logic [7:0]  GAIN_INIT_C = 8'(GAIN_INIT);
    localparam logic [8:0]  GAIN_MIN_C  = 9'(GAIN_MIN);
    localparam logic [8:0]  GAIN_MAX_C  = 9'(GAIN_MAX);
    localparam logic [8:0]  GAIN_STEP_C = 9'(GAIN_STEP);
    localparam logic [11:0] HI_THR_C    = 12'(HI_THR);
    localparam logic [11:0] LO_THR_C    = 12'(LO_THR);

    state_t      state_q, state_d;
    logic [15:0] period_cnt;
    logic [15:0] wait_cnt;
    logic [95:0] cap_data;
    logic [11:0] band_max;
    logic [8:0]  gain_up;
    logic [7:0]  gain_next;
    logic        trig_go;

    // The trigger lands on the cycle after this decision, so compare the
    // count the period counter will hold then; this spaces triggers exactly
    // frame_period cycles apart when the frame finishes early enough.
    assign trig_go = enable && (({1'b0, period_cnt} + 17'd1) >= {1'b0, frame_period});

    always_comb begin
        state_d     = state_q;
        fft_trigger = 1'b0;
        frame_valid = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_go) state_d = S_TRIG;
            end
            S_TRIG: begin
                fft_trigger = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle is still accepted.
                if (fft_valid) begin
                    state_d = S_LATCH;
                end else if (wait_cnt == TIMEOUT_C) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_LATCH: begin
                frame_valid = 1'b1;
                state_d     = S_AGC;
            end
            S_AGC: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        band_max = '0;
        for (int k = 0; k < 8; k++) begin
            if (frame_data[12*k +: 12] > band_max) band_max = frame_data[12*k +: 12];
        end
    end

    // Gain arithmetic is carried in 9 bits so the clamps never see a wrap.
    always_comb begin
        gain_up   = {1'b0, fft_gain} + GAIN_STEP_C;
        gain_next = fft_gain;
        if (agc_en) begin
            if (band_max > HI_THR_C) begin
                if ({1'b0, fft_gain} >= (GAIN_MIN_C + GAIN_STEP_C))
                    gain_next = fft_gain - GAIN_STEP_C[7:0];
                else
                    gain_next = GAIN_MIN_C[7:0];
            end else if (band_max < LO_THR_C) begin
                gain_next = (gain_up > GAIN_MAX_C) ? GAIN_MAX_C[7:0] : gain_up[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            period_cnt <= '0;
            wait_cnt   <= '0;
            fft_mode   <= '0;
            fft_gain   <= GAIN_INIT_C;
            cap_data   <= '0;
            frame_data <= '0;
            frame_cnt  <= '0;
        end else begin
            state_q <= state_d;

            // Reads 0 on the trigger cycle, then counts up and saturates.
            if (state_q == S_IDLE && state_d == S_TRIG)
                period_cnt <= '0;
            else if (period_cnt != 16'hFFFF)
                period_cnt <= period_cnt + 16'd1;

            if (state_q == S_TRIG) begin
                wait_cnt <= '0;
                fft_mode <= mode_cfg;
            end else if (state_q == S_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (state_q == S_WAIT && fft_valid) cap_data <= fft_data;

            if (state_q == S_LATCH) begin
                frame_data <= cap_data;
                frame_cnt  <= frame_cnt + 16'd1;
            end

            if (state_q == S_AGC) fft_gain <= gain_next;
        end
    end

`ifdef FFT_PEAK_HOLD_EN
    logic [95:0] peak_q;
    logic [95:0] peak_next;

    always_comb begin
        peak_next = peak_q;
        for (int k = 0; k < 8; k++) begin
            if (cap_data[12*k +: 12] > peak_q[12*k +: 12])
                peak_next[12*k +: 12] = cap_data[12*k +: 12];
            else
                peak_next[12*k +: 12] = peak_q[12*k +: 12] - (peak_q[12*k +: 12] >> DECAY_SHIFT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak_q <= '0;
        else if (state_q == S_LATCH)
            peak_q <= peak_next;
    end

    assign peak_data = peak_q;
`else
    assign peak_data = frame_data;
`endif

endmodule
